// File: rtl/fp32_addsub_arbiter.sv
// rtl/fp32_addsub_arbiter.sv - round-robin sharing of one fixed-latency fp32 add/sub pipe
module fp32_addsub_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADD_LATENCY = 4,
    parameter int IDX_W       = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_op,
    output logic [31:0]             add_dina,
    output logic [31:0]             add_dinb,
    output logic                    add_op,
    output logic                    add_valid_in,
    input  logic [31:0]             add_result,
    input  logic                    add_valid_out,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_data,
    output logic                    busy,
    output logic                    err_orphan
);

    logic [IDX_W-1:0]       ptr;
    logic [IDX_W-1:0]       issue_idx;
    logic [IDX_W-1:0]       grant_idx;
    logic                   grant_any;
    logic [NUM_REQ-1:0]     grant;
    logic [31:0]            sel_a;
    logic [31:0]            sel_b;
    logic                   sel_op;
    logic [ADD_LATENCY-1:0] tag_valid;
    logic [IDX_W-1:0]       tag_idx [ADD_LATENCY];
    logic                   xfer;

    // Search starts just after the last winner so every requester gets a turn.
    always_comb begin
        int cand;
        cand      = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        grant     = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_op    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!grant_any && req_valid[cand]) begin
                grant_any   = 1'b1;
                grant_idx   = IDX_W'(cand);
                grant[cand] = 1'b1;
                sel_a       = req_a[32*cand +: 32];
                sel_b       = req_b[32*cand +: 32];
                sel_op      = req_op[cand];
            end
        end
    end

    assign req_ready = en ? grant : '0;
    assign xfer      = en & grant_any;
    assign busy      = add_valid_in | (|tag_valid) | (|rsp_valid);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr          <= IDX_W'(NUM_REQ - 1);
            issue_idx    <= '0;
            add_dina     <= '0;
            add_dinb     <= '0;
            add_op       <= 1'b0;
            add_valid_in <= 1'b0;
        end else begin
            add_valid_in <= xfer;
            if (xfer) begin
                ptr       <= grant_idx;
                issue_idx <= grant_idx;
                add_dina  <= sel_a;
                add_dinb  <= sel_b;
                add_op    <= sel_op;
            end
        end
    end

    // Stage 0 captures alongside the adder's input sample; last stage lines up with add_valid_out.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_valid <= '0;
            for (int s = 0; s < ADD_LATENCY; s++) begin
                tag_idx[s] <= '0;
            end
        end else begin
            tag_valid[0] <= add_valid_in;
            tag_idx[0]   <= issue_idx;
            for (int s = 1; s < ADD_LATENCY; s++) begin
                tag_valid[s] <= tag_valid[s-1];
                tag_idx[s]   <= tag_idx[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= '0;
            if (add_valid_out && tag_valid[ADD_LATENCY-1]) begin
                rsp_valid[tag_idx[ADD_LATENCY-1]] <= 1'b1;
                rsp_data                          <= add_result;
            end
            if (add_valid_out != tag_valid[ADD_LATENCY-1]) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp32_addsub_arbiter.sv
// tb/tb_fp32_addsub_arbiter.sv - randomized self-checking bench for fp32_addsub_arbiter
module tb_fp32_addsub_arbiter;

    localparam int N = 4;
    localparam int L = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N-1:0]    req_op = '0;
    logic [31:0]     add_dina;
    logic [31:0]     add_dinb;
    logic            add_op;
    logic            add_valid_in;
    logic [31:0]     add_result;
    logic            add_valid_out;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic            busy;
    logic            err_orphan;
    logic            orph_force = 1'b0;

    fp32_addsub_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L), .IDX_W(2)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .add_dina(add_dina), .add_dinb(add_dinb), .add_op(add_op),
        .add_valid_in(add_valid_in), .add_result(add_result),
        .add_valid_out(add_valid_out),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Real-valued fp32 helpers: enough for normal operands whose results are normal or zero.
    function automatic real f2r(logic [31:0] x);
        real m;
        int  e;
        e = int'(x[30:23]);
        if (e == 0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        while (e > 127) begin m = m * 2.0; e--; end
        while (e < 127) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] r2f(real v);
        logic        s;
        int          e;
        real         x;
        logic [22:0] m;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        x = s ? -v : v;
        e = 127;
        while (x >= 2.0) begin x = x / 2.0; e++; end
        while (x < 1.0) begin x = x * 2.0; e--; end
        m = 23'($rtoi((x - 1.0) * 8388608.0));
        return {s, 8'(e), m};
    endfunction

    function automatic logic [31:0] fadd(logic [31:0] a, logic [31:0] b, logic op);
        return op ? r2f(f2r(a) - f2r(b)) : r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // Stand-in adder: fixed latency, shares rstn with the arbiter.
    logic [L-1:0] ap_v;
    logic [31:0]  ap_res [L];
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ap_v <= '0;
        end else begin
            ap_v[0]   <= add_valid_in;
            ap_res[0] <= fadd(add_dina, add_dinb, add_op);
            for (int s = 1; s < L; s++) begin
                ap_v[s]   <= ap_v[s-1];
                ap_res[s] <= ap_res[s-1];
            end
        end
    end
    assign add_valid_out = ap_v[L-1] | orph_force;
    assign add_result    = ap_res[L-1];

    typedef struct {
        int          idx;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sq[$];
    int   mptr = N - 1;
    logic prev_xfer = 1'b0;
    bit   mon_on = 1'b0;

    function automatic int rr_pick(logic [N-1:0] v, int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : monitor
        int          g;
        logic [31:0] er;
        exp_t        e;
        if (mon_on && rstn) begin
            g  = en ? rr_pick(req_valid, mptr) : -1;
            er = (g < 0) ? 32'h0 : (32'h1 << g);
            check("req_ready", 32'(req_ready), er);
            check("add_valid_in", 32'(add_valid_in), 32'(prev_xfer));
            if (rsp_valid != '0) begin
                if (sq.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'h0);
                end else begin
                    e = sq.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'h1 << e.idx);
                    check("rsp_data", rsp_data, e.data);
                    check("rsp_latency", 32'(cyc - e.cyc), 32'(L + 2));
                end
            end else if (sq.size() != 0 && (cyc - sq[0].cyc) >= L + 2) begin
                check("rsp_missing", 32'(rsp_valid), 32'h1 << sq[0].idx);
                void'(sq.pop_front());
            end
            if (g >= 0) begin
                e.idx  = g;
                e.data = fadd(req_a[32*g +: 32], req_b[32*g +: 32], req_op[g]);
                e.cyc  = cyc;
                sq.push_back(e);
                mptr      = g;
                prev_xfer = 1'b1;
            end else begin
                prev_xfer = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic op);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_op[i]         = op;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'h0);
        check({tag, "_avin"}, 32'(add_valid_in), 32'h0);
        check({tag, "_rsp"}, 32'(rsp_valid), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_orphan"}, 32'(err_orphan), 32'h0);
    endtask

    initial begin
        tick();
        tick();
        check_idle_outputs("reset");
        check("reset_dina", add_dina, 32'h0);
        check("reset_rspdata", rsp_data, 32'h0);
        rstn   = 1'b1;
        mon_on = 1'b1;
        en     = 1'b1;
        tick();

        // T3 fairness from reset pointer
        for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 1'($urandom));
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("t3_grant", 32'(req_ready), 32'h1 << (k % N));
            tick();
        end
        req_valid = '0;
        repeat (L + 4) tick();

        // T1 single add from requester 0
        set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        repeat (5) tick();
        check("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        check("t1_rsp_data", rsp_data, 32'h40400000);
        repeat (2) tick();

        // T2 subtract routed to requester 2
        set_req(2, 32'h40A00000, 32'h40A00000, 1'b1);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (5) tick();
        check("t2_rsp_valid", 32'(rsp_valid), 32'h4);
        check("t2_rsp_data", rsp_data, 32'h0);
        repeat (2) tick();

        // T4 enable gating
        en = 1'b0;
        set_req(1, rnd_fp(), rnd_fp(), 1'b0);
        req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_ready_off", 32'(req_ready), 32'h0);
            tick();
        end
        en = 1'b1;
        #1;
        check("t4_ready_on", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        check("t4_avin", 32'(add_valid_in), 32'h1);
        repeat (L + 3) tick();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < N; i++) set_req(i, rnd_fp(), rnd_fp(), 1'($urandom));
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            en        = ($urandom_range(0, 7) != 0);
            tick();
        end
        req_valid = '0;
        en        = 1'b1;
        repeat (L + 4) tick();
        check("drain_busy", 32'(busy), 32'h0);
        check("drain_queue", 32'(sq.size()), 32'h0);

        // T5 reset with ops in flight
        req_valid = '1;
        repeat (3) tick();
        req_valid = '0;
        rstn      = 1'b0;
        sq.delete();
        mptr      = N - 1;
        prev_xfer = 1'b0;
        #1;
        check_idle_outputs("t5_in_reset");
        tick();
        tick();
        rstn = 1'b1;
        repeat (L + 4) tick();
        check("t5_rsp", 32'(rsp_valid), 32'h0);
        check("t5_busy", 32'(busy), 32'h0);
        check("t5_orphan", 32'(err_orphan), 32'h0);

        // T6 orphan result with empty tag pipe
        orph_force = 1'b1;
        tick();
        orph_force = 1'b0;
        check("t6_orphan", 32'(err_orphan), 32'h1);
        check("t6_rsp", 32'(rsp_valid), 32'h0);
        repeat (3) tick();
        check("t6_sticky", 32'(err_orphan), 32'h1);
        check("t6_rsp_after", 32'(rsp_valid), 32'h0);

        mon_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
